// File: rtl/seg7_pkg.sv
// Shared types and the seven-segment glyph table for the scan driver.
// Segment vectors are logical-on, ordered a (bit 6) down to g (bit 0).
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b0000000;

  localparam seg_t SEG_LUT [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  function automatic seg_t hex_to_seg(input logic [3:0] nibble, input logic hex_en);
    if (!hex_en && (nibble > 4'd9)) begin
      return SEG_BLANK;
    end
    return SEG_LUT[nibble];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-segment lookup; codes 10..15 blank when hex is off.
module seg7_decode
  import seg7_pkg::*;
#(
  parameter bit HEX_EN = 1'b1
) (
  input  logic [3:0] i_nibble,
  output seg_t       o_seg
);

  assign o_seg = hex_to_seg(i_nibble, HEX_EN);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit seven-segment driver with guard interval, leading-zero
// blanking and frame-aligned display updates; all pins are registered.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int GUARD      = 16,
  parameter bit HEX_EN     = 1'b1,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_GUARD = DIV_W'(GUARD);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  localparam seg_t                  SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = ACTIVE_LOW ? '1 : '0;

  logic [DIV_W-1:0]        r_div;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_disp_val;
  logic [NUM_DIGITS-1:0]   r_disp_dp;
  logic [4*NUM_DIGITS-1:0] r_pend_val;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic                    r_pend_flag;
  logic                    r_blank_lz;
  seg_t                    r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_frame_start;

  logic                    w_wrap;
  logic                    w_frame;
  logic                    w_active;
  logic [3:0]              w_nib [NUM_DIGITS];
  logic [NUM_DIGITS:0]     w_zero_from;
  logic [NUM_DIGITS-1:0]   w_an_onehot;
  logic [3:0]              w_sel_nib;
  logic                    w_lz_blank;
  seg_t                    w_seg_dec;

  assign w_wrap   = (r_div == DIV_LAST);
  assign w_frame  = w_wrap && (r_idx == IDX_LAST);
  assign w_active = (r_div >= DIV_GUARD);

  // w_zero_from[k]: display nibbles k..NUM_DIGITS-1 are all zero
  assign w_zero_from[NUM_DIGITS] = 1'b1;
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign w_nib[gi]       = r_disp_val[4*gi +: 4];
    assign w_zero_from[gi] = (w_nib[gi] == 4'd0) && w_zero_from[gi+1];
    assign w_an_onehot[gi] = (r_idx == IDX_W'(gi));
  end

  assign w_sel_nib  = w_nib[r_idx];
  assign w_lz_blank = r_blank_lz && (r_idx != '0) && w_zero_from[r_idx];

  seg7_decode #(.HEX_EN(HEX_EN)) u_decode (
    .i_nibble (w_sel_nib),
    .o_seg    (w_seg_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div      <= '0;
      r_idx      <= '0;
      r_blank_lz <= 1'b0;
    end else begin
      r_div <= w_wrap ? '0 : r_div + 1'b1;
      if (w_wrap) begin
        r_idx      <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        r_blank_lz <= blank_lz;
      end
    end
  end

  // A load coinciding with the frame boundary bypasses the pending register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp_val  <= '0;
      r_disp_dp   <= '0;
      r_pend_val  <= '0;
      r_pend_dp   <= '0;
      r_pend_flag <= 1'b0;
    end else if (w_frame && load) begin
      r_disp_val  <= value;
      r_disp_dp   <= dp_in;
      r_pend_flag <= 1'b0;
    end else if (w_frame && r_pend_flag) begin
      r_disp_val  <= r_pend_val;
      r_disp_dp   <= r_pend_dp;
      r_pend_flag <= 1'b0;
    end else if (load) begin
      r_pend_val  <= value;
      r_pend_dp   <= dp_in;
      r_pend_flag <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg         <= SEG_OFF;
      r_dp          <= DP_OFF;
      r_an          <= AN_OFF;
      r_frame_start <= 1'b0;
    end else begin
      r_seg         <= ((w_active && !w_lz_blank) ? w_seg_dec : SEG_BLANK) ^ SEG_OFF;
      r_dp          <= (w_active && r_disp_dp[r_idx]) ^ DP_OFF;
      r_an          <= (w_active ? w_an_onehot : '0) ^ AN_OFF;
      r_frame_start <= (r_div == '0) && (r_idx == '0);
    end
  end

  assign seg         = r_seg;
  assign dp          = r_dp;
  assign an          = r_an;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed plus randomized bench for seg7_scan_driver against a cycle-count
// reference model of the scan schedule and frame-aligned display updates.
module tb_seg7_scan_driver;

  localparam int ND    = 4;
  localparam int SD    = 8;
  localparam int GD    = 2;
  localparam int FRAME = SD * ND;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SD),
    .GUARD      (GD),
    .HEX_EN     (1'b1),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .value       (value),
    .dp_in       (dp_in),
    .blank_lz    (blank_lz),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_start (frame_start)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: m_c = cycles since reset release whose state drives the next output
  int          m_c;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_disp_dp, m_pend_dp;
  bit          m_pflag;
  bit          m_blz;

  logic [6:0] glyph [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @cycle %0d: observed %h expected %h", tag, m_c, obs, exp);
    end
  endtask

  task automatic chk_inactive(input string tag);
    chk({tag, "_an"},  16'(an),          16'h000F);
    chk({tag, "_seg"}, 16'(seg),         16'h007F);
    chk({tag, "_dp"},  16'(dp),          16'h0001);
    chk({tag, "_fs"},  16'(frame_start), 16'h0000);
  endtask

  task automatic model_reset();
    m_c = 0; m_disp = '0; m_pend = '0; m_disp_dp = '0; m_pend_dp = '0;
    m_pflag = 1'b0; m_blz = 1'b0;
  endtask

  task automatic cyc(input bit ld, input logic [15:0] v, input logic [3:0] d);
    int div, idx, nib;
    bit active, blanked;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_fs;
    load = ld; value = v; dp_in = d;
    @(posedge clk);
    div     = m_c % SD;
    idx     = (m_c / SD) % ND;
    active  = (div >= GD);
    nib     = int'((m_disp >> (4 * idx)) & 16'hF);
    blanked = m_blz && (idx > 0) && ((m_disp >> (4 * idx)) == 16'd0);
    e_an    = active ? ~(4'd1 << idx) : 4'hF;
    e_seg   = (active && !blanked) ? ~glyph[nib] : 7'h7F;
    e_dp    = active ? ~m_disp_dp[idx] : 1'b1;
    e_fs    = (div == 0) && (idx == 0);
    if (div == SD - 1) m_blz = blank_lz;
    if ((m_c % FRAME) == FRAME - 1) begin
      if (ld) begin
        m_disp = v; m_disp_dp = d; m_pflag = 1'b0;
      end else if (m_pflag) begin
        m_disp = m_pend; m_disp_dp = m_pend_dp; m_pflag = 1'b0;
      end
    end else if (ld) begin
      m_pend = v; m_pend_dp = d; m_pflag = 1'b1;
    end
    m_c++;
    #1;
    load = 1'b0;
    chk("an",  16'(an),          16'(e_an));
    chk("seg", 16'(seg),         16'(e_seg));
    chk("dp",  16'(dp),          16'(e_dp));
    chk("fs",  16'(frame_start), 16'(e_fs));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, value, dp_in);
  endtask

  task automatic goto_pos(input int p);
    while ((m_c % FRAME) != p) cyc(1'b0, value, dp_in);
  endtask

  initial begin
    model_reset();
    repeat (3) begin
      @(posedge clk); #1;
      chk_inactive("reset");
    end
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    run(2 * FRAME);

    // mid-frame load, shown only from the next frame
    goto_pos(10);
    cyc(1'b1, 16'h12A7, 4'b0100);
    run(2 * FRAME);

    // leading-zero blanking on and off
    goto_pos(10);
    cyc(1'b1, 16'h0050, 4'b0000);
    goto_pos(7); blank_lz = 1'b1;
    run(2 * FRAME);
    goto_pos(7); blank_lz = 1'b0;
    run(FRAME + 8);

    // load exactly at the frame boundary
    goto_pos(FRAME - 1);
    cyc(1'b1, 16'hBEEF, 4'b1001);
    run(FRAME + 4);

    // two loads in one frame: last wins
    goto_pos(5);
    cyc(1'b1, 16'h1111, 4'b0001);
    goto_pos(20);
    cyc(1'b1, 16'h2222, 4'b0010);
    run(2 * FRAME);

    // randomized loads and blanking changes
    for (int i = 0; i < 600; i++) begin
      if ((m_c % FRAME) == 7) blank_lz = 1'($urandom_range(0, 1));
      cyc(($urandom_range(0, 9) == 0), 16'($urandom), 4'($urandom));
    end

    // async reset mid digit-2 slot with a pending load
    goto_pos(7); blank_lz = 1'b0;
    goto_pos(18);
    cyc(1'b1, 16'h9876, 4'b1111);
    run(2);
    #2 rst_n = 1'b0;
    #1 chk_inactive("async_rst");
    repeat (2) begin
      @(posedge clk); #1;
      chk_inactive("in_rst");
    end
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    run(3 * FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
